// File: rtl/uart_rx_button_if.sv
// -----------------------------------------------------------------------------
// uart_rx_button_if
//   Bundles the serial line, received-byte strobe and decoded button vector of
//   the UART-to-button front end.
//
//   Handshake: rx_valid and frame_err are one-cycle strobes with no ready or
//   back-pressure. rx_data is valid in the cycle rx_valid is high and holds
//   that value until the next good frame. Bytes are never buffered, so a
//   consumer that misses the strobe loses the byte.
//
//   Signals
//     rx         serial input, idle high (driven by master)
//     rx_data    last good byte received
//     rx_valid   one-cycle strobe, rx_data valid in the same cycle
//     frame_err  one-cycle strobe on bad stop bit (or parity error if enabled)
//     button     decoded key pulse: [0]=left [1]=drop [2]=rotate [3]=right
//     busy       high whenever the receiver FSM is not idle
//     state_dbg  raw FSM state encoding for observation
//
//   Modports
//     master  host / bench side: drives rx, observes everything else
//     slave   receiver side: consumes rx, drives everything else
// -----------------------------------------------------------------------------
interface uart_rx_button_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic [3:0] button;
   logic       busy;
   logic [2:0] state_dbg;

   modport master (
      output rx,
      input  rx_data, rx_valid, frame_err, button, busy, state_dbg
   );

   modport slave (
      input  rx,
      output rx_data, rx_valid, frame_err, button, busy, state_dbg
   );
endinterface

// File: rtl/uart_rx_button.sv
// -----------------------------------------------------------------------------
// uart_rx_button
//   Serial-to-button front end for the tetris game core. Receives UART bytes
//   (8N1 by default), presents each good byte with a one-cycle strobe and
//   decodes the keys a/s/w/d into PULSE_LEN-cycle pulses on a 4-bit button
//   vector that is ORed with the physical push-buttons upstream.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//     PULSE_LEN     cycles a decoded button bit stays high (>= 1)
//
//   Ports
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    uart_rx_button_if.slave (rx in; rx_data, rx_valid, frame_err,
//            button, busy, state_dbg out)
//
//   Configuration macro
//     PARITY_EN  when defined the frame is 8E1: a PARITY state samples one
//                extra bit and an odd overall XOR of data+parity raises
//                frame_err instead of rx_valid. Undefined: plain 8N1.
// -----------------------------------------------------------------------------
module uart_rx_button #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PULSE_LEN    = 4
) (
   input logic             clk,
   input logic             reset,
   uart_rx_button_if.slave bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PULSE_MAX = PW'(PULSE_LEN - 1);

`ifdef PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd4,
      S_BREAK = 3'd5
   } state_t;
`endif

   state_t          state_q, state_d;
   logic            rx_meta_q, rx_s_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic [3:0]      button_q, button_d;
   logic [PW-1:0]   pulse_q, pulse_d;
`ifdef PARITY_EN
   logic            par_err_q, par_err_d;
`endif

   logic            cnt_zero;
   logic [3:0]      key_code;

   assign cnt_zero = (cnt_q == '0);

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         // Synchronizer preloads idle-high so reset never looks like a start bit.
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         button_q    <= '0;
         pulse_q     <= '0;
`ifdef PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         rx_meta_q   <= bus.rx;
         rx_s_q      <= rx_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         button_q    <= button_d;
         pulse_q     <= pulse_d;
`ifdef PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rx_s_q) state_d = S_START;
         // A start bit that is high again at its centre was a glitch.
         S_START: if (cnt_zero) state_d = rx_s_q ? S_IDLE : S_DATA;
`ifdef PARITY_EN
         S_DATA:   if (cnt_zero && bit_idx_q == 3'd7) state_d = S_PARITY;
         S_PARITY: if (cnt_zero) state_d = S_STOP;
`else
         S_DATA:   if (cnt_zero && bit_idx_q == 3'd7) state_d = S_STOP;
`endif
         // A low stop bit parks in BREAK so a held-low line reports only once.
         S_STOP:  if (cnt_zero) state_d = rx_s_q ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath / outputs
   always_comb begin
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef PARITY_EN
      par_err_d   = par_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            // Half a bit to land on the centre of the start bit.
            if (!rx_s_q) cnt_d = CNT_HALF;
         end
         S_START: begin
            if (cnt_zero) begin
               cnt_d     = CNT_FULL;
               bit_idx_d = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_zero) begin
               shift_d   = {rx_s_q, shift_q[7:1]};   // LSB arrives first
               bit_idx_d = bit_idx_q + 3'd1;
               cnt_d     = CNT_FULL;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef PARITY_EN
         S_PARITY: begin
            if (cnt_zero) begin
               // Even parity: data bits plus parity bit must XOR to zero.
               par_err_d = ^{shift_q, rx_s_q};
               cnt_d     = CNT_FULL;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (cnt_zero) begin
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
`ifdef PARITY_EN
               end else if (par_err_q) begin
                  frame_err_d = 1'b1;
`endif
               end else begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- key decode
   always_comb begin
      case (rx_data_q)
         8'h61:   key_code = 4'b0001;   // 'a' left
         8'h73:   key_code = 4'b0010;   // 's' drop
         8'h77:   key_code = 4'b0100;   // 'w' rotate
         8'h64:   key_code = 4'b1000;   // 'd' right
         default: key_code = 4'b0000;   // anything else cancels a live pulse
      endcase
   end

   always_comb begin
      button_d = button_q;
      pulse_d  = pulse_q;
      if (rx_valid_q) begin
         button_d = key_code;
         pulse_d  = PULSE_MAX;
      end else if (button_q != 4'b0000) begin
         if (pulse_q == '0) button_d = 4'b0000;
         else               pulse_d  = pulse_q - 1'b1;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.button    = button_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_button.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_button
//   Directed bench for uart_rx_button with CLKS_PER_BIT=8, PULSE_LEN=4.
//   Inputs change and outputs are checked 1 time unit after a rising edge; a
//   falling-edge monitor logs strobes, received bytes and button activity.
// -----------------------------------------------------------------------------
module tb_uart_rx_button;

   localparam int CPB = 8;
   localparam int PL  = 4;

   // ------------------------------------------------------------ clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_rx_button_if bus();

   uart_rx_button #(
      .CLKS_PER_BIT(CPB),
      .PULSE_LEN   (PL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // ------------------------------------------------------------ bookkeeping
   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rcv_mem[64];
   int         rd_idx = 0;

   int         cyc = 0;
   int         valid_cnt = 0;
   int         ferr_cnt = 0;
   int         last_valid_cyc = -1;
   int         last_btn_cyc = -1;
   int         btn_hi[4] = '{default: 0};
   logic [3:0] prev_btn = 4'b0000;

`ifdef PARITY_EN
   logic par_flip = 1'b0;
`endif

   // Monitor: observes outputs on the falling edge, far from the active edge.
   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         if (valid_cnt < 64) rcv_mem[valid_cnt] = bus.rx_data;
         valid_cnt      = valid_cnt + 1;
         last_valid_cyc = cyc;
      end
      if (bus.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
      if (bus.button != 4'b0000 && bus.button != prev_btn) last_btn_cyc = cyc;
      for (int i = 0; i < 4; i++) if (bus.button[i] === 1'b1) btn_hi[i] = btn_hi[i] + 1;
      prev_btn = bus.button;
      cyc      = cyc + 1;
   end

   // ------------------------------------------------------------ driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      bus.rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         tick(CPB);
      end
`ifdef PARITY_EN
      bus.rx = (^b) ^ par_flip;
      tick(CPB);
`endif
      bus.rx = stop_bit;
      tick(CPB);
      bus.rx = 1'b1;
   endtask

   // ------------------------------------------------------------ checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every byte pushed on exp_q must have appeared on rx_valid, in order.
   task automatic check_bytes(input string tag);
      logic [7:0] e;
      check({tag, "_count"}, 32'(valid_cnt - rd_idx), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < valid_cnt) check({tag, "_data"}, 32'(rcv_mem[rd_idx]), 32'(e));
         rd_idx = rd_idx + 1;
      end
      rd_idx = valid_cnt;
   endtask

   int f0;
   int b0[4];

   task automatic mark();
      f0 = ferr_cnt;
      for (int i = 0; i < 4; i++) b0[i] = btn_hi[i];
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      reset  = 1'b1;
      bus.rx = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);

      // Power-on reset state
      check("rst_rx_data",   32'(bus.rx_data),   32'h00);
      check("rst_rx_valid",  32'(bus.rx_valid),  32'h0);
      check("rst_frame_err", 32'(bus.frame_err), 32'h0);
      check("rst_button",    32'(bus.button),    32'h0);
      check("rst_busy",      32'(bus.busy),      32'h0);

      // 1. Reset held 3 cycles mid-frame
      mark();
      bus.rx = 1'b0;
      tick(20);
      check("t1_busy_mid_frame", 32'(bus.busy), 32'h1);
      reset  = 1'b1;
      bus.rx = 1'b1;
      tick(3);
      check("t1_rx_data",   32'(bus.rx_data),   32'h00);
      check("t1_rx_valid",  32'(bus.rx_valid),  32'h0);
      check("t1_frame_err", 32'(bus.frame_err), 32'h0);
      check("t1_button",    32'(bus.button),    32'h0);
      check("t1_busy",      32'(bus.busy),      32'h0);
      reset = 1'b0;
      tick(100);
      check_bytes("t1_no_strobe");
      check("t1_ferr_none", 32'(ferr_cnt - f0), 32'd0);
      check("t1_rx_data_after", 32'(bus.rx_data), 32'h00);

      // 2. 'a' -> left pulse of exactly PL cycles starting after rx_valid
      mark();
      exp_q.push_back(8'h61);
      send_frame(8'h61, 1'b1);
      tick(10);
      check_bytes("t2_a");
      check("t2_btn_start",  32'(last_btn_cyc), 32'(last_valid_cyc + 1));
      check("t2_left_len",   32'(btn_hi[0] - b0[0]), 32'd4);
      check("t2_other_btns", 32'(btn_hi[1] - b0[1] + btn_hi[2] - b0[2] + btn_hi[3] - b0[3]), 32'd0);
      check("t2_ferr_none",  32'(ferr_cnt - f0), 32'd0);
      check("t2_button_off", 32'(bus.button), 32'h0);

      // 3. 'w' then 'd' back-to-back, then a non-key byte
      mark();
      exp_q.push_back(8'h77);
      exp_q.push_back(8'h64);
      send_frame(8'h77, 1'b1);
      send_frame(8'h64, 1'b1);
      tick(10);
      check_bytes("t3_wd");
      check("t3_rotate_len", 32'(btn_hi[2] - b0[2]), 32'd4);
      check("t3_right_len",  32'(btn_hi[3] - b0[3]), 32'd4);
      check("t3_d_start",    32'(last_btn_cyc), 32'(last_valid_cyc + 1));
      check("t3_ferr_none",  32'(ferr_cnt - f0), 32'd0);
      mark();
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1);
      tick(10);
      check_bytes("t3_nonkey");
      check("t3_nonkey_btns", 32'(btn_hi[0] - b0[0] + btn_hi[1] - b0[1] + btn_hi[2] - b0[2] + btn_hi[3] - b0[3]), 32'd0);
      check("t3_nonkey_data", 32'(bus.rx_data), 32'h41);

      // 4. Start glitch of 2 cycles
      mark();
      bus.rx = 1'b0;
      tick(2);
      bus.rx = 1'b1;
      tick(2);
      check("t4_busy_during", 32'(bus.busy), 32'h1);
      tick(20);
      check("t4_busy_after", 32'(bus.busy), 32'h0);
      check_bytes("t4_glitch");
      check("t4_ferr_none", 32'(ferr_cnt - f0), 32'd0);

      // 5. Bad stop bit with line held low, then recovery with 's'
      mark();
      send_frame(8'h55, 1'b0);
      bus.rx = 1'b0;
      tick(40);
      check("t5_busy_break", 32'(bus.busy), 32'h1);
      bus.rx = 1'b1;
      tick(10);
      check("t5_ferr_once",  32'(ferr_cnt - f0), 32'd1);
      check("t5_rx_data",    32'(bus.rx_data), 32'h41);
      check("t5_busy_after", 32'(bus.busy), 32'h0);
      check_bytes("t5_bad_stop");
      mark();
      exp_q.push_back(8'h73);
      send_frame(8'h73, 1'b1);
      tick(10);
      check_bytes("t5_s");
      check("t5_drop_len",   32'(btn_hi[1] - b0[1]), 32'd4);
      check("t5_s_start",    32'(last_btn_cyc), 32'(last_valid_cyc + 1));
      check("t5_ferr_none",  32'(ferr_cnt - f0), 32'd0);

`ifdef PARITY_EN
      // 6. Even parity: 8'h64 has three ones, so the correct parity bit is 1
      mark();
      par_flip = 1'b0;
      exp_q.push_back(8'h64);
      send_frame(8'h64, 1'b1);
      tick(10);
      check_bytes("t6_par_good");
      check("t6_right_len", 32'(btn_hi[3] - b0[3]), 32'd4);
      check("t6_ferr_none", 32'(ferr_cnt - f0), 32'd0);
      mark();
      par_flip = 1'b1;
      send_frame(8'h64, 1'b1);
      par_flip = 1'b0;
      tick(10);
      check_bytes("t6_par_bad");
      check("t6_ferr_once", 32'(ferr_cnt - f0), 32'd1);
      check("t6_no_button", 32'(btn_hi[3] - b0[3]), 32'd0);
      check("t6_busy",      32'(bus.busy), 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
